// File: rtl/game_state_fsm.sv
// game_state_fsm -- top-level game sequencer.
//
// Watches the player controller's collision flag and level, and drives back
// the game state code and the level-reset request. Owns the lives counter,
// the CLEAN hold interval and the game-over / win handling.
//
// Ports:
//   i_Clk         system clock (single domain)
//   i_Reset       synchronous, active-high reset
//   i_Start       debounced start button (level)
//   i_Collision   collision flag (level)
//   i_Level       current level from the player controller
//   o_Game_State  00 IDLE, 01 RUN, 10 GAME_OVER, 11 CLEAN
//   o_Reset_Level level-reset request to the player controller
//   o_Lives       remaining lives
//   o_Win         high in GAME_OVER when it was reached by winning
//
// Optional feature: define LEVEL_BONUS_EN to award a life (saturating at 7)
// on every non-winning level-up in RUN.
module game_state_fsm #(
    parameter int LIVES        = 3,
    parameter int CLEAN_CYCLES = 4194304,
    parameter int OVER_CYCLES  = 25000000,
    parameter int WIN_LEVEL    = 9,
    parameter int TIMER_W      = 25
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Collision,
    input  logic [3:0] i_Level,
    output logic [1:0] o_Game_State,
    output logic       o_Reset_Level,
    output logic [2:0] o_Lives,
    output logic       o_Win
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_OVER  = 2'b10,
        S_CLEAN = 2'b11
    } state_t;

    localparam logic [TIMER_W-1:0] CLEAN_LAST = TIMER_W'(CLEAN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OVER_LAST  = TIMER_W'(OVER_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]         WIN_LVL    = 4'(WIN_LEVEL);

    state_t             state, state_n;
    logic [2:0]         lives, lives_n;
    logic               win, win_n;
    logic               reset_level, reset_level_n;
    logic [TIMER_W-1:0] timer, timer_n, timer_inc;

    // Prior-cycle input samples for edge detection
    logic       start_q, coll_q;
    logic [3:0] level_q;

    logic start_re, coll_re, lvl_up;

    assign start_re  = i_Start & ~start_q;
    assign coll_re   = i_Collision & ~coll_q;
    assign lvl_up    = i_Level > level_q;
    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + 1'b1;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            lives       <= LIVES_INIT;
            win         <= 1'b0;
            reset_level <= 1'b0;
            timer       <= '0;
            // Load current inputs so nothing looks like an edge right after reset
            start_q     <= i_Start;
            coll_q      <= i_Collision;
            level_q     <= i_Level;
        end else begin
            state       <= state_n;
            lives       <= lives_n;
            win         <= win_n;
            reset_level <= reset_level_n;
            timer       <= timer_n;
            start_q     <= i_Start;
            coll_q      <= i_Collision;
            level_q     <= i_Level;
        end
    end

    always_comb begin
        state_n       = state;
        lives_n       = lives;
        win_n         = win;
        reset_level_n = reset_level;
        timer_n       = timer;

        unique case (state)
            S_IDLE: begin
                if (start_re) begin
                    state_n       = S_CLEAN;
                    lives_n       = LIVES_INIT;
                    win_n         = 1'b0;
                    reset_level_n = 1'b1;
                    timer_n       = '0;
                end
            end

            S_CLEAN: begin
                // All edges ignored; reset_level holds the value set on entry
                if (timer == CLEAN_LAST) begin
                    state_n       = S_RUN;
                    reset_level_n = 1'b0;
                    timer_n       = '0;
                end else begin
                    timer_n = timer_inc;
                end
            end

            S_RUN: begin
                // Collision outranks the win check when both land together
                if (coll_re) begin
                    timer_n = '0;
                    if (lives <= 3'd1) begin
                        state_n = S_OVER;
                        lives_n = 3'd0;
                        win_n   = 1'b0;
                    end else begin
                        state_n       = S_CLEAN;
                        lives_n       = lives - 3'd1;
                        reset_level_n = 1'b0;
                    end
                end else if (lvl_up && (i_Level == WIN_LVL)) begin
                    state_n = S_OVER;
                    win_n   = 1'b1;
                    timer_n = '0;
                end
`ifdef LEVEL_BONUS_EN
                else if (lvl_up && (lives != 3'd7)) begin
                    lives_n = lives + 3'd1;
                end
`else
`endif
            end

            S_OVER: begin
                // Early start presses are dropped, not remembered
                if (timer == OVER_LAST) begin
                    if (start_re) begin
                        state_n       = S_CLEAN;
                        lives_n       = LIVES_INIT;
                        win_n         = 1'b0;
                        reset_level_n = 1'b1;
                        timer_n       = '0;
                    end
                end else begin
                    timer_n = timer_inc;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign o_Game_State  = state;
    assign o_Reset_Level = reset_level;
    assign o_Lives       = lives;
    assign o_Win         = win;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed testbench for game_state_fsm with CLEAN_CYCLES=4, OVER_CYCLES=8,
// LIVES=3. Inputs change 1 time unit after the rising edge; outputs are
// checked at that same point.
module tb_game_state_fsm;

`ifdef LEVEL_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       coll;
    logic [3:0] level;
    logic [1:0] st;
    logic       rl;
    logic [2:0] lives;
    logic       win;

    int vectors = 0;
    int miscompares = 0;

    game_state_fsm #(
        .LIVES(3), .CLEAN_CYCLES(4), .OVER_CYCLES(8), .WIN_LEVEL(9), .TIMER_W(25)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Collision(coll),
        .i_Level(level), .o_Game_State(st), .o_Reset_Level(rl),
        .o_Lives(lives), .o_Win(win)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_st, input logic [2:0] e_lives,
                           input logic e_rl, input logic e_win);
        chk({tag, ".state"}, 8'(st), 8'(e_st));
        chk({tag, ".lives"}, 8'(lives), 8'(e_lives));
        chk({tag, ".rl"}, 8'(rl), 8'(e_rl));
        chk({tag, ".win"}, 8'(win), 8'(e_win));
    endtask

    // Called right after the CLEAN-entry edge: four cycles of CLEAN, then RUN
    task automatic clean_hold(input string tag, input logic e_rl, input logic [2:0] e_lives);
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".clean_st"}, 8'(st), 8'h3);
            chk({tag, ".clean_rl"}, 8'(rl), 8'(e_rl));
            tick();
        end
        chk_all({tag, ".run"}, 2'b01, e_lives, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_coll();
        coll = 1'b1;
        tick();
        coll = 1'b0;
    endtask

    logic [2:0] exp_l;

    initial begin
        rst = 1'b1; start = 1'b1; coll = 1'b0; level = 4'd0;
        tick(); tick();
        rst = 1'b0;
        chk_all("reset", 2'b00, 3'd3, 1'b0, 1'b0);
        // start held high through reset must not count as an edge
        tick();
        chk_all("no_edge_after_reset", 2'b00, 3'd3, 1'b0, 1'b0);
        start = 1'b0;
        tick();

        // 1: start -> CLEAN with reset_level for 4 cycles -> RUN
        pulse_start();
        chk_all("s1.enter", 2'b11, 3'd3, 1'b1, 1'b0);
        clean_hold("s1", 1'b1, 3'd3);

        // 2: held collision decrements once
        coll = 1'b1;
        tick();
        chk_all("s2.hit", 2'b11, 3'd2, 1'b0, 1'b0);
        clean_hold("s2", 1'b0, 3'd2);
        for (int i = 0; i < 5; i++) tick();
        chk_all("s2.held", 2'b01, 3'd2, 1'b0, 1'b0);
        coll = 1'b0;
        tick();

        // 3: three collisions to game over, early start ignored
        rst = 1'b1; tick(); rst = 1'b0;
        pulse_start();
        clean_hold("s3.start", 1'b1, 3'd3);
        pulse_coll();
        chk_all("s3.hit1", 2'b11, 3'd2, 1'b0, 1'b0);
        clean_hold("s3.h1", 1'b0, 3'd2);
        pulse_coll();
        chk_all("s3.hit2", 2'b11, 3'd1, 1'b0, 1'b0);
        clean_hold("s3.h2", 1'b0, 3'd1);
        pulse_coll();
        chk_all("s3.over", 2'b10, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();   // timer = 5
        pulse_start();                         // sampled at timer 5
        chk_all("s3.early_start", 2'b10, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();   // timer saturated at 8
        chk_all("s3.still_over", 2'b10, 3'd0, 1'b0, 1'b0);
        level = 4'd8;                          // level moves are ignored here
        pulse_start();
        chk_all("s3.restart", 2'b11, 3'd3, 1'b1, 1'b0);
        clean_hold("s3.r", 1'b1, 3'd3);

        // 4: level 8 -> 9 wins
        level = 4'd9;
        tick();
        chk_all("s4.win", 2'b10, 3'd3, 1'b0, 1'b1);
        level = 4'd8;
        for (int i = 0; i < 8; i++) tick();
        pulse_start();
        chk_all("s4.restart", 2'b11, 3'd3, 1'b1, 1'b0);
        clean_hold("s4.r", 1'b1, 3'd3);
        level = 4'd9; coll = 1'b1;
        tick();
        chk_all("s4.coll_wins", 2'b11, 3'd2, 1'b0, 1'b0);
        coll = 1'b0;

        // 5: reset mid-CLEAN and in GAME_OVER
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk_all("s5.rst_clean", 2'b00, 3'd3, 1'b0, 1'b0);
        level = 4'd8;
        pulse_start();
        clean_hold("s5.s", 1'b1, 3'd3);
        level = 4'd9;
        tick();
        chk_all("s5.over", 2'b10, 3'd3, 1'b0, 1'b1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk_all("s5.rst_over", 2'b00, 3'd3, 1'b0, 1'b0);

        // 6: level bonus (or its absence)
        pulse_start();
        clean_hold("s6.s", 1'b1, 3'd3);
        pulse_coll();
        clean_hold("s6.c", 1'b0, 3'd2);
        level = 4'd3;                          // downward step
        tick();
        chk("s6.down", 8'(lives), 8'd2);
        exp_l = 3'd2;
        for (int l = 4; l <= 8; l++) begin
            level = 4'(l);
            tick();
            if (BONUS && exp_l != 3'd7) exp_l = exp_l + 3'd1;
            chk("s6.lvl_up", 8'(lives), 8'(exp_l));
        end
        level = 4'd1; tick();
        level = 4'd2; tick();
        chk("s6.sat", 8'(lives), 8'(exp_l));
        chk("s6.state", 8'(st), 8'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
